// File: rtl/tick_ctrl_pkg.sv
// tick_ctrl_pkg: shared defaults, mode and channel-state encodings for tick_ctrl.
package tick_ctrl_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  typedef enum logic [1:0] {MODE_OFF, MODE_PERIODIC, MODE_ONESHOT, MODE_RSVD} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DONE} state_e;
  function automatic logic mode_active(input logic [1:0] m);
    return m == MODE_PERIODIC || m == MODE_ONESHOT;
  endfunction
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one tick channel - tap mux, rising-edge detect, one-shot counter and FSM.
module tick_chan
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [4:0]       sel_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [31:0]      clk_div_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o
);
  state_e           state_q, state_d;
  logic [4:0]       sel_q, sel_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic             tap, rise, oneshot;
  assign tap     = clk_div_i[sel_q];
  assign rise    = tap & ~prev_q;
  assign oneshot = mode_q == MODE_ONESHOT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      mode_q  <= MODE_OFF;
      rem_q   <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end
  // A write overrides everything, which also drops an edge detected in the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    prev_d  = prev_q;
    tick_d  = 1'b0;
    if (wr_i) begin
      sel_d   = sel_i;
      mode_d  = mode_i;
      rem_d   = cnt_i;
      prev_d  = 1'b0;
      state_d = mode_active(mode_i) ? ST_ARM : ST_IDLE;
    end else begin
      case (state_q)
        ST_ARM: begin
          prev_d  = tap;
          state_d = (oneshot && rem_q == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          prev_d = tap;
          tick_d = rise;
          rem_d  = (rise && oneshot) ? rem_q - CNT_W'(1) : rem_q;
          state_d = (rise && oneshot && rem_q == CNT_W'(1)) ? ST_DONE : ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end
  assign tick_o = tick_q;
  assign busy_o = state_q == ST_ARM || state_q == ST_RUN;
  assign done_o = state_q == ST_DONE;
endmodule

// File: rtl/tick_ctrl.sv
// tick_ctrl: configuration handshake and channel decode over NUM_CH tick_chan instances.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       clk_div,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [4:0]        cfg_sel,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_cnt,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);
  logic acc, acc_q;
  assign acc       = cfg_valid & cfg_ready;
  assign cfg_ready = ~acc_q;
  always_ff @(posedge clk) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= acc;
  end
  // Channel numbers with no instance match no decode term and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (acc && cfg_ch == CH_W'(i)),
      .sel_i     (cfg_sel),
      .mode_i    (cfg_mode),
      .cnt_i     (cfg_cnt),
      .clk_div_i (clk_div),
      .tick_o    (tick[i]),
      .busy_o    (busy[i]),
      .done_o    (done[i])
    );
  end
endmodule

// File: tb/tb_tick_ctrl.sv
// tb_tick_ctrl: directed self-checking bench for tick_ctrl.
module tb_tick_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] clk_div = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [4:0]  cfg_sel = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_cnt = '0;
  logic [3:0]  tick, busy, done;
  int errors = 0;
  int checks = 0;
  int tstamp[$];
  int dstamp[$];
  tick_ctrl dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_cnt(cfg_cnt),
    .tick(tick), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) clk_div <= rst ? 32'd0 : clk_div + 32'd1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ch, input int sel, input int mode, input int cnt);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_sel   = 5'(sel);
    cfg_mode  = 2'(mode);
    cfg_cnt   = 16'(cnt);
    step();
    cfg_valid = 1'b0;
  endtask
  task automatic watch(input int n, input int c);
    tstamp.delete();
    dstamp.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (tick[c]) begin
        tstamp.push_back(i);
        dstamp.push_back(int'(done[c]));
      end
    end
  endtask
  function automatic int bad_gaps(input int gap);
    int b = 0;
    for (int i = 1; i < tstamp.size(); i++) if (tstamp[i] - tstamp[i-1] != gap) b++;
    return b;
  endfunction
  initial begin
    int n;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    rst = 1'b0;
    step();
    // ch0 periodic on tap 0
    wr(0, 0, 1, 0);
    chk("p_tick_after_wr", tick[0], 0);
    chk("p_ready_after_wr", cfg_ready, 0);
    watch(21, 0);
    chk("p_count_ge9", tstamp.size() >= 9, 1);
    chk("p_first_latency", tstamp.size() > 0 && tstamp[0] <= 2, 1);
    chk("p_gap2", bad_gaps(2), 0);
    chk("p_busy", busy[0], 1);
    chk("p_done", done[0], 0);
    // ch1 one-shot, tap 3, three ticks
    wr(1, 3, 2, 3);
    chk("o_tick_after_wr", tick[1], 0);
    watch(70, 1);
    chk("o_count", tstamp.size(), 3);
    chk("o_gap16", bad_gaps(16), 0);
    if (dstamp.size() == 3) begin
      chk("o_done_at_t2", dstamp[1], 0);
      chk("o_done_at_t3", dstamp[2], 1);
    end
    chk("o_busy_end", busy[1], 0);
    chk("o_done_end", done[1], 1);
    // ch2 one-shot with zero count
    wr(2, 0, 2, 0);
    chk("z_arm_busy", busy[2], 1);
    chk("z_arm_done", done[2], 0);
    step();
    chk("z_done", done[2], 1);
    chk("z_busy", busy[2], 0);
    watch(10, 2);
    chk("z_no_tick", tstamp.size(), 0);
    // back-to-back requests: second waits one cycle
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_sel = 5'd1; cfg_mode = 2'd1; cfg_cnt = '0;
    step();
    cfg_ch = 2'd2; cfg_sel = 5'd0; cfg_mode = 2'd1;
    chk("bb_ready_b", cfg_ready, 0);
    chk("bb_ch3_busy", busy[3], 1);
    step();
    chk("bb_ready_c", cfg_ready, 1);
    chk("bb_ch2_still_done", done[2], 1);
    step();
    cfg_valid = 1'b0;
    chk("bb_ready_d", cfg_ready, 0);
    chk("bb_ch2_done_clr", done[2], 0);
    chk("bb_ch2_busy", busy[2], 1);
    // ch0 OFF written in a cycle with a pending edge
    n = 0;
    for (int i = 0; i < 4 && n == 0; i++) begin
      step();
      if (tick[0]) n = 1;
    end
    chk("off_found_tick", n, 1);
    step();
    chk("off_pending_cycle", tick[0], 0);
    wr(0, 0, 0, 0);
    chk("off_no_tick", tick[0], 0);
    chk("off_busy", busy[0], 0);
    watch(10, 0);
    chk("off_quiet", tstamp.size(), 0);
    // reset in the middle of a one-shot
    wr(1, 3, 2, 5);
    n = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      step();
      if (tick[1]) n++;
    end
    chk("r_two_ticks", n, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_tick", tick, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_ready", cfg_ready, 1);
    watch(40, 1);
    chk("r_ch1_quiet", tstamp.size(), 0);
    chk("r_all_idle", busy | tick, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 NUM_CH, 4, number of independent tick channels (1-8).
REQ-002 CNT_W, 16, width of the one-shot tick count.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clk_div  in  32  free-running divider count; bit k toggles at clk/2^(k+1).
REQ-006 cfg_valid  in  1  configuration write request.
REQ-007 cfg_ready  out  1  configuration write accepted when high with cfg_valid.
REQ-008 cfg_ch  in  clog2(NUM_CH)  target channel.
REQ-009 cfg_sel  in  5  clk_div tap index for the channel.
REQ-010 cfg_mode  in  2  0=OFF, 1=PERIODIC, 2=ONESHOT, 3=reserved (treated as OFF).
REQ-011 cfg_cnt  in  CNT_W  number of ticks in ONESHOT mode.
REQ-012 tick  out  NUM_CH  one-cycle clock-enable pulse per channel.
REQ-013 busy  out  NUM_CH  channel is in ARM or RUN.
REQ-014 done  out  NUM_CH  sticky one-shot completion flag.

Function
REQ-015 A write is accepted on a rising clk edge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 0 in the cycle after an accepted write and 1 otherwise (maximum one write per 2 cycles).
REQ-016 An accepted write to channel c latches sel/mode/cnt and clears done[c]; tick[c] SHALL be 0 in the cycle after the write.
REQ-017 Per-channel FSM states: IDLE, ARM, RUN, DONE.
REQ-018 IDLE: tick=0, busy=0; a write with mode PERIODIC or ONESHOT -> ARM; mode OFF/reserved -> IDLE.
REQ-019 ARM (exactly 1 cycle): load prev[c] with clk_div[sel]; no tick; -> RUN, except ONESHOT with cnt=0 -> DONE with done=1 and zero ticks.
REQ-020 RUN: each cycle prev[c] <= clk_div[sel]; on clk_div[sel]=1 and prev[c]=0 the channel SHALL assert tick[c] in the following cycle for exactly one cycle.
REQ-021 Tick latency: tick[c] is high in the cycle after the first cycle in which the sampled tap is high; tap 0 yields one tick every 2 cycles.
REQ-022 ONESHOT: a remaining-count register, loaded with cnt, decrements per tick; on the tick that brings it to 0 the FSM -> DONE and done[c] rises in the same cycle as that final tick.
REQ-023 DONE: tick=0, busy=0, done=1 held until the next accepted write to that channel.
REQ-024 PERIODIC: stays in RUN indefinitely; the count register is unused; done stays 0.
REQ-025 A write to a channel in any state SHALL abort the current activity and restart at ARM (or IDLE if OFF); a tick edge detected in the write cycle SHALL be discarded.
REQ-026 Channels are fully independent; a write affects only cfg_ch; simultaneous ticks on several channels are allowed.
REQ-027 cfg_ch >= NUM_CH is accepted and ignored.

Reset
REQ-028 While rst=1 at a clock edge: all FSMs -> IDLE, tick=0, busy=0, done=0, prev=0, counts=0, sel=0, cfg_ready=1 on the following cycle.
REQ-029 Reset asserted mid-RUN or mid-ONESHOT SHALL suppress any pending tick; no tick in the cycle after reset.

Structure
REQ-030 Mode encodings, FSM state encodings, and the NUM_CH/CNT_W defaults SHALL reside in the shared project header/package.
REQ-031 One sub-module, tick_chan, SHALL implement a single channel (FSM, tap mux, edge detect, counter); tick_ctrl instantiates NUM_CH copies and owns the config handshake and decode.

Verification
REQ-032 Reset then write ch0 PERIODIC sel=0 with clk_div driven as a counter -> tick[0] pulses every 2 cycles, busy[0]=1, done[0]=0.
REQ-033 Write ch1 ONESHOT sel=3 cnt=3 -> exactly 3 tick[1] pulses spaced 16 cycles apart; done[1] rises with the 3rd pulse; busy[1] falls.
REQ-034 Write ch2 ONESHOT cnt=0 -> no tick; done[2]=1 two cycles after the write.
REQ-035 Back-to-back cfg_valid for 2 cycles -> the first is accepted; cfg_ready=0 in the second cycle; the second is accepted in the third cycle.
REQ-036 Rewrite ch0 to OFF while running at sel=0, issued in a cycle with a pending edge -> no tick after the write; busy[0]=0.
REQ-037 Assert rst during ch1 ONESHOT cnt=5 after 2 ticks -> all outputs are 0 the next cycle; no further ticks until a rewrite.
